// File: rtl/hamming_dec_if.sv
// Handshake/result bundle for the SECDED decoder: codeword in, corrected data,
// syndrome, error flags and error counters out.
interface hamming_dec_if #(
  parameter int K     = 8,
  parameter int CNT_W = 16
);
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m = m + 1;
    return m;
  endfunction

  localparam int M = calc_m(K);
  localparam int N = M + K;

  logic             valid_i;
  logic             ready_o;
  logic [N:0]       q_i;
  logic             valid_o;
  logic             ready_i;
  logic [K-1:0]     d_o;
  logic [M-1:0]     syndrome_o;
  logic             sb_err_o;
  logic             db_err_o;
  logic             clr_cnt_i;
  logic [CNT_W-1:0] sb_cnt_o;
  logic [CNT_W-1:0] db_cnt_o;

  modport slave (
    input  valid_i, q_i, ready_i, clr_cnt_i,
    output ready_o, valid_o, d_o, syndrome_o, sb_err_o, db_err_o, sb_cnt_o, db_cnt_o
  );

  modport master (
    output valid_i, q_i, ready_i, clr_cnt_i,
    input  ready_o, valid_o, d_o, syndrome_o, sb_err_o, db_err_o, sb_cnt_o, db_cnt_o
  );
endinterface

// File: rtl/hamming_dec.sv
// Two-stage SECDED Hamming decoder: S1 registers the codeword, S2 registers the
// decoded result; valid/ready backpressure with saturating error counters.
module hamming_dec #(
  parameter int K      = 8,
  parameter int P0_LSB = 1,
  parameter int CNT_W  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  hamming_dec_if.slave bus
);
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m = m + 1;
    return m;
  endfunction

  localparam int M = calc_m(K);
  localparam int N = M + K;

  // Codeword positions covered by syndrome bit b: those with bit b of the index set.
  function automatic logic [N:1] syn_mask(input int b);
    logic [N:1] mk;
    mk = '0;
    for (int j = 1; j <= N; j++) mk[j] = (((j >> b) & 1) == 1);
    return mk;
  endfunction

  // Codeword position of data bit i: the i-th non-power-of-2 position.
  function automatic int data_pos(input int i);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (cnt == i) pos = j;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

  logic             r_s1_vld;
  logic [N:0]       r_s1_q;
  logic             r_s2_vld;
  logic [K-1:0]     r_d;
  logic [M-1:0]     r_syn;
  logic             r_sb;
  logic             r_db;
  logic [CNT_W-1:0] r_sb_cnt;
  logic [CNT_W-1:0] r_db_cnt;

  logic             w_s2_ld;
  logic             w_s1_ld;
  logic             w_out_xfer;
  logic [N:1]       w_cw;
  logic             w_p0;
  logic [M-1:0]     w_syn;
  logic             w_par;
  logic [N:1]       w_fix;
  logic             w_sb;
  logic             w_db;
  logic [K-1:0]     w_data;

  assign w_s2_ld    = r_s1_vld && (!r_s2_vld || bus.ready_i);
  assign w_s1_ld    = !r_s1_vld || w_s2_ld;
  assign w_out_xfer = r_s2_vld && bus.ready_i;

  generate
    if (P0_LSB != 0) begin : g_p0_lsb
      assign w_cw = r_s1_q[N:1];
      assign w_p0 = r_s1_q[0];
    end else begin : g_p0_msb
      assign w_cw = r_s1_q[N-1:0];
      assign w_p0 = r_s1_q[N];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_syn
      localparam logic [N:1] MASK = syn_mask(gi);
      assign w_syn[gi] = ^(w_cw & MASK);
    end
  endgenerate

  assign w_par = (^w_cw) ^ w_p0;

  // Odd overall parity with an in-range syndrome is a single error; a zero
  // syndrome in that case means only the overall parity bit flipped.
  always_comb begin
    w_fix = w_cw;
    w_sb  = 1'b0;
    w_db  = 1'b0;
    if (w_par && (int'(w_syn) <= N)) begin
      w_sb = 1'b1;
      for (int j = 1; j <= N; j++) begin
        if (int'(w_syn) == j) w_fix[j] = ~w_cw[j];
      end
    end else if (w_par || (w_syn != '0)) begin
      w_db = 1'b1;
    end
  end

  generate
    for (genvar gd = 0; gd < K; gd++) begin : g_data
      localparam int POS = data_pos(gd);
      assign w_data[gd] = w_fix[POS];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
      r_s1_q   <= '0;
      r_s2_vld <= 1'b0;
      r_d      <= '0;
      r_syn    <= '0;
      r_sb     <= 1'b0;
      r_db     <= 1'b0;
    end else begin
      if (w_s1_ld) begin
        r_s1_vld <= bus.valid_i;
        if (bus.valid_i) r_s1_q <= bus.q_i;
      end
      if (w_s2_ld) begin
        r_s2_vld <= 1'b1;
        r_d      <= w_data;
        r_syn    <= w_syn;
        r_sb     <= w_sb;
        r_db     <= w_db;
      end else if (bus.ready_i) begin
        r_s2_vld <= 1'b0;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clr_cnt_i) begin
      r_sb_cnt <= '0;
      r_db_cnt <= '0;
    end else if (w_out_xfer) begin
      if (r_sb && (r_sb_cnt != '1)) r_sb_cnt <= r_sb_cnt + CNT_W'(1);
      if (r_db && (r_db_cnt != '1)) r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign bus.ready_o    = w_s1_ld;
  assign bus.valid_o    = r_s2_vld;
  assign bus.d_o        = r_d;
  assign bus.syndrome_o = r_syn;
  assign bus.sb_err_o   = r_sb;
  assign bus.db_err_o   = r_db;
  assign bus.sb_cnt_o   = r_sb_cnt;
  assign bus.db_cnt_o   = r_db_cnt;
endmodule

// File: tb/tb_hamming_dec.sv
// Bench for hamming_dec: directed vectors plus random traffic scored against a
// position-XOR reference decoder; a second instance uses P0 at the MSB and CNT_W=2.
module tb_hamming_dec;
  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic       sb;
    logic       db;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_dec_if #(.K(8), .CNT_W(16)) b0 ();
  hamming_dec_if #(.K(8), .CNT_W(2))  b1 ();

  assign b1.valid_i   = b0.valid_i;
  assign b1.ready_i   = b0.ready_i;
  assign b1.clr_cnt_i = b0.clr_cnt_i;
  assign b1.q_i       = {b0.q_i[0], b0.q_i[12:1]};

  hamming_dec #(.K(8), .P0_LSB(1), .CNT_W(16)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  hamming_dec #(.K(8), .P0_LSB(0), .CNT_W(2))  u_dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));

  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  res_t sbq[$];
  int   m_sb16 = 0, m_db16 = 0, m_sb2 = 0, m_db2 = 0;
  bit   held = 1'b0;
  res_t h_r;
  res_t e_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encode by placing data at non-power-of-2 positions, then setting check bits
  // so the XOR of all set positions becomes zero.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] w;
    int s, k;
    w = '0; s = 0; k = 0;
    for (int j = 1; j <= 12; j++) begin
      if ($countones(j) != 1) begin
        w[j] = d[k];
        if (d[k]) s = s ^ j;
        k++;
      end
    end
    for (int b = 0; b < 4; b++) if (((s >> b) & 1) == 1) w[1 << b] = 1'b1;
    w[0] = ^w[12:1];
    return w;
  endfunction

  function automatic res_t ref_dec(input logic [12:0] q);
    res_t r;
    logic [12:0] c;
    int s, k;
    bit par;
    c = q; s = 0; par = q[0]; k = 0;
    for (int j = 1; j <= 12; j++) if (q[j]) begin s = s ^ j; par = ~par; end
    r.s = s[3:0]; r.sb = 1'b0; r.db = 1'b0; r.d = '0;
    if (par && s == 0) r.sb = 1'b1;
    else if (par && s <= 12) begin r.sb = 1'b1; c[s] = ~c[s]; end
    else if (s != 0 || par) r.db = 1'b1;
    for (int j = 1; j <= 12; j++) if ($countones(j) != 1) begin r.d[k] = c[j]; k++; end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("sb_cnt16", 32'(b0.sb_cnt_o), m_sb16);
      chk("db_cnt16", 32'(b0.db_cnt_o), m_db16);
      chk("sb_cnt2",  32'(b1.sb_cnt_o), m_sb2);
      chk("db_cnt2",  32'(b1.db_cnt_o), m_db2);
      if (rst) begin
        sbq.delete();
        m_sb16 = 0; m_db16 = 0; m_sb2 = 0; m_db2 = 0;
        held = 1'b0;
      end else begin
        if (held && b0.valid_o) begin
          chk("hold_d",   32'(b0.d_o), 32'(h_r.d));
          chk("hold_syn", 32'(b0.syndrome_o), 32'(h_r.s));
          chk("hold_sb",  32'(b0.sb_err_o), 32'(h_r.sb));
          chk("hold_db",  32'(b0.db_err_o), 32'(h_r.db));
        end
        if (b0.valid_i && b0.ready_o) sbq.push_back(ref_dec(b0.q_i));
        if (b0.valid_o && b0.ready_i) begin
          if (sbq.size() == 0) chk("spurious_out", 32'd1, 32'd0);
          else begin
            e_r = sbq.pop_front();
            chk("d0",   32'(b0.d_o), 32'(e_r.d));
            chk("syn0", 32'(b0.syndrome_o), 32'(e_r.s));
            chk("sb0",  32'(b0.sb_err_o), 32'(e_r.sb));
            chk("db0",  32'(b0.db_err_o), 32'(e_r.db));
            chk("vld1", 32'(b1.valid_o), 32'd1);
            chk("d1",   32'(b1.d_o), 32'(e_r.d));
            chk("syn1", 32'(b1.syndrome_o), 32'(e_r.s));
            chk("sb1",  32'(b1.sb_err_o), 32'(e_r.sb));
            chk("db1",  32'(b1.db_err_o), 32'(e_r.db));
            if (!b0.clr_cnt_i) begin
              if (e_r.sb) begin
                if (m_sb16 < 65535) m_sb16++;
                if (m_sb2 < 3) m_sb2++;
              end
              if (e_r.db) begin
                if (m_db16 < 65535) m_db16++;
                if (m_db2 < 3) m_db2++;
              end
            end
          end
        end
        if (b0.clr_cnt_i) begin m_sb16 = 0; m_db16 = 0; m_sb2 = 0; m_db2 = 0; end
        held = b0.valid_o && !b0.ready_i;
        h_r.d = b0.d_o; h_r.s = b0.syndrome_o; h_r.sb = b0.sb_err_o; h_r.db = b0.db_err_o;
      end
    end
  end

  // Single word through an idle pipeline with ready_i=1; result checked at valid_o.
  task automatic send_one(input logic [12:0] q, input logic [7:0] ed, input logic [3:0] es,
                          input logic esb, input logic edb, input string tag);
    b0.valid_i = 1'b1; b0.q_i = q;
    step();
    b0.valid_i = 1'b0;
    step();
    chk({tag, "_vld"}, 32'(b0.valid_o), 32'd1);
    chk({tag, "_d"},   32'(b0.d_o), 32'(ed));
    chk({tag, "_syn"}, 32'(b0.syndrome_o), 32'(es));
    chk({tag, "_sb"},  32'(b0.sb_err_o), 32'(esb));
    chk({tag, "_db"},  32'(b0.db_err_o), 32'(edb));
    step();
  endtask

  logic [12:0] rq;
  int p1, nf;

  initial begin
    b0.valid_i = 1'b0; b0.ready_i = 1'b1; b0.clr_cnt_i = 1'b0; b0.q_i = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_vld", 32'(b0.valid_o), 32'd0);
    chk("rst_rdy", 32'(b0.ready_o), 32'd1);
    chk("rst_sbc", 32'(b0.sb_cnt_o), 32'd0);
    chk("rst_dbc", 32'(b0.db_cnt_o), 32'd0);
    mon_en = 1'b1;

    send_one(13'h144E, 8'hA5, 4'd0,  1'b0, 1'b0, "clean");
    send_one(13'h140E, 8'hA5, 4'd6,  1'b1, 1'b0, "sb_cw6");
    send_one(13'h144F, 8'hA5, 4'd0,  1'b1, 1'b0, "sb_p0");
    send_one(13'h1466, 8'hA6, 4'd6,  1'b0, 1'b1, "db_3_5");
    send_one(13'h0448, 8'h25, 4'd15, 1'b0, 1'b1, "db_s15");
    for (int i = 0; i < 4; i++) send_one(13'h140E, 8'hA5, 4'd6, 1'b1, 1'b0, "sb_rep");
    chk("sat_sb2", 32'(b1.sb_cnt_o), 32'd3);
    chk("db_cnt16", 32'(b0.db_cnt_o), 32'd2);

    // Clear coincident with an error transfer
    b0.valid_i = 1'b1; b0.q_i = 13'h140E;
    step();
    b0.valid_i = 1'b0;
    step();
    b0.clr_cnt_i = 1'b1;
    step();
    b0.clr_cnt_i = 1'b0;
    chk("clr_sb16", 32'(b0.sb_cnt_o), 32'd0);
    chk("clr_sb2",  32'(b1.sb_cnt_o), 32'd0);

    // Backpressure: two words fill S1/S2, then ready_o drops
    b0.ready_i = 1'b0; b0.valid_i = 1'b1; b0.q_i = 13'h144E;
    step();
    b0.q_i = 13'h140E;
    step();
    b0.q_i = 13'h1466;
    chk("bp_rdy", 32'(b0.ready_o), 32'd0);
    chk("bp_vld", 32'(b0.valid_o), 32'd1);
    chk("bp_d",   32'(b0.d_o), 32'hA5);
    step(); step(); step();
    chk("bp_d_held", 32'(b0.d_o), 32'hA5);
    b0.ready_i = 1'b1;
    step();
    b0.q_i = 13'h144F;
    step();
    b0.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_drain", sbq.size(), 32'd0);

    // Reset with both stages full
    b0.ready_i = 1'b0; b0.valid_i = 1'b1; b0.q_i = 13'h140E;
    step(); step();
    chk("mid_full", 32'(b0.ready_o), 32'd0);
    rst = 1'b1; b0.valid_i = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_vld",  32'(b0.valid_o), 32'd0);
    chk("mid_rdy",  32'(b0.ready_o), 32'd1);
    chk("mid_sbc",  32'(b0.sb_cnt_o), 32'd0);
    chk("mid_sbc2", 32'(b1.sb_cnt_o), 32'd0);
    b0.ready_i = 1'b1;
    step();
    chk("mid_vld2", 32'(b0.valid_o), 32'd0);

    // Random traffic with backpressure and occasional clears
    for (int it = 0; it < 500; it++) begin
      b0.valid_i   = ($urandom_range(0, 3) != 0);
      b0.ready_i   = ($urandom_range(0, 9) < 7);
      b0.clr_cnt_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) rq = 13'($urandom);
      else begin
        rq = enc(8'($urandom));
        nf = $urandom_range(0, 2);
        p1 = $urandom_range(0, 12);
        if (nf > 0) rq[p1] = ~rq[p1];
        if (nf == 2) begin
          p1 = (p1 + $urandom_range(1, 12)) % 13;
          rq[p1] = ~rq[p1];
        end
      end
      b0.q_i = rq;
      step();
    end
    b0.valid_i = 1'b0; b0.ready_i = 1'b1; b0.clr_cnt_i = 1'b0;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
    chk("final_drain", sbq.size(), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hamming_dec.md
HAMMING_DEC -- requirements
Module: hamming_dec

Interface
REQ-001 SHALL have parameter K, default 8: data width in bits.
REQ-002 SHALL have parameter P0_LSB, default 1: 1 = overall parity in q_i[0], codeword in q_i[n:1]; 0 = overall parity in q_i[n], codeword in q_i[n-1:0].
REQ-003 SHALL have parameter CNT_W, default 16: error counter width.
REQ-004 SHALL derive m (smallest m with 2^m >= m+K+1) and n = m+K; K=8 gives m=4, n=12.
REQ-005 clk_i  input  1  clock; all logic on rising edge.
REQ-006 rst_i  input  1  reset; synchronous, active-high.
REQ-007 valid_i  input  1  codeword valid.
REQ-008 ready_o  output  1  decoder accepts codeword.
REQ-009 q_i  input  n+1  SECDED codeword, Hamming positions 1..n plus overall parity.
REQ-010 valid_o  output  1  decoded result valid.
REQ-011 ready_i  input  1  downstream accepts result.
REQ-012 d_o  output  K  decoded/corrected data.
REQ-013 syndrome_o  output  m  Hamming syndrome of the word on d_o.
REQ-014 sb_err_o  output  1  single-bit error detected and corrected.
REQ-015 db_err_o  output  1  uncorrectable error detected.
REQ-016 clr_cnt_i  input  1  synchronous clear of both counters.
REQ-017 sb_cnt_o  output  CNT_W  count of sb_err_o output transfers.
REQ-018 db_cnt_o  output  CNT_W  count of db_err_o output transfers.

Function
REQ-019 Input transfer SHALL occur on a cycle with valid_i && ready_o; output transfer on valid_o && ready_i.
REQ-020 Two register stages: S1 captures q_i; S2 holds decode result and drives all result outputs; latency 2 cycles from input transfer to valid_o when S2 is not stalled.
REQ-021 S2 loads when S1 valid and (!valid_o || ready_i); S1 loads when !S1 valid or S2 loads; ready_o = !S1 valid || S2 loads; throughput one word/cycle.
REQ-022 While valid_o && !ready_i, d_o, syndrome_o, sb_err_o, db_err_o SHALL hold stable; no word is dropped or duplicated.
REQ-023 Syndrome bit i (1..m) = XOR of cw[j] for all j in 1..n with bit (i-1) of j set; overall parity P = XOR of cw[n:1] and the p0 bit.
REQ-024 s=0, P=0: no error; both flags 0.
REQ-025 s!=0, P=1, s<=n: flip cw[s]; sb_err_o=1.
REQ-026 s=0, P=1: error in p0 only; data unchanged; sb_err_o=1.
REQ-027 s!=0, P=0, or s>n with P=1: db_err_o=1; d_o = uncorrected extracted data.
REQ-028 d_o SHALL be cw bits at non-power-of-2 positions in ascending order, position 3 -> d_o[0].
REQ-029 sb_err_o and db_err_o SHALL never both be 1.
REQ-030 Counters increment by 1 on output transfer with the matching flag and saturate at 2^CNT_W-1.
REQ-031 clr_cnt_i SHALL clear both counters to 0 next cycle; clear wins over same-cycle increment.

Reset
REQ-032 While rst_i is high at a clock edge: S1/S2 valid, valid_o, d_o, syndrome_o, flags, and both counters SHALL go to 0; ready_o SHALL be 1 the cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL discard in-flight words; no valid_o for them after reset.

Verification
REQ-034 K=8, P0_LSB=1, q_i=0x144E, ready_i=1 -> 2 cycles later valid_o=1, d_o=0xA5, syndrome_o=0, flags 0.
REQ-035 q_i=0x140E (cw[6] flipped) -> d_o=0xA5, syndrome_o=6, sb_err_o=1, sb_cnt_o +1; q_i=0x144F -> d_o=0xA5, syndrome_o=0, sb_err_o=1.
REQ-036 q_i=0x1466 (cw[3], cw[5] flipped) -> syndrome_o=6, db_err_o=1, d_o=0xA6, db_cnt_o +1; q_i=0x0448 -> syndrome_o=15, db_err_o=1.
REQ-037 Stream 4 words with valid_i=1, ready_i=0 -> ready_o drops after 2 accepted, valid_o held with first result stable; raise ready_i -> all 4 results out in order, no loss.
REQ-038 CNT_W=2, 5 single-error transfers -> sb_cnt_o=3; clr_cnt_i with same-cycle error transfer -> sb_cnt_o=0.
REQ-039 rst_i pulsed with S1 and S2 full -> next cycle valid_o=0, counters 0, ready_o=1 after deassert.
